// File: rtl/tx_frame_scheduler_if.sv
// Requester and GMII-side signals of the transmit frame scheduler.
// The master modport is the requester/PHY side; the slave modport is the scheduler.
interface tx_frame_scheduler_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       last0;
  logic       last1;
  logic       gnt0;
  logic       gnt1;
  logic       rd0;
  logic       rd1;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       busy;

  modport master (
    output req0, req1, data0, data1, last0, last1,
    input  gnt0, gnt1, rd0, rd1, TXD, TX_EN, TX_ER, busy
  );

  modport slave (
    input  req0, req1, data0, data1, last0, last1,
    output gnt0, gnt1, rd0, rd1, TXD, TX_EN, TX_ER, busy
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Two-requester round-robin GMII frame scheduler: emits preamble, SFD, frame
// bytes (one-cycle latency from rd) and a fixed inter-packet gap.
module tx_frame_scheduler #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_CYCLES   = 11
) (
  input logic                 gtx_clk,
  input logic                 mr_main_reset,
  tx_frame_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    IPG
  } state_e;

  localparam logic [4:0] PRE_RELOAD = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] IPG_RELOAD = 5'(IPG_CYCLES - 1);
  localparam logic [7:0] PRE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE   = 8'hD5;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic       done_q, done_d;
  logic [7:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_er_q, tx_er_d;

  logic       req_g;
  logic [7:0] data_g;
  logic       last_g;
  logic       rd_g;
  logic       pick;

  // Mux the granted requester; done_q marks that the frame's final byte (or an
  // underrun) has been taken, so the current DATA cycle is the last one.
  always_comb begin
    req_g  = gnt_q[1] ? bus.req1  : bus.req0;
    data_g = gnt_q[1] ? bus.data1 : bus.data0;
    last_g = gnt_q[1] ? bus.last1 : bus.last0;
    rd_g   = (state_q == SFD) || ((state_q == DATA) && !done_q);
  end

  // last_gnt_q holds the index of the requester granted most recently.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_gnt_q;
    end else if (bus.req1) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    done_d     = done_q;
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d    = PREAMBLE;
          cnt_d      = PRE_RELOAD;
          gnt_d      = pick ? 2'b10 : 2'b01;
          last_gnt_d = pick;
          done_d     = 1'b0;
          txd_d      = PRE_BYTE;
          tx_en_d    = 1'b1;
        end
      end

      PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = SFD;
          txd_d   = SFD_BYTE;
        end else begin
          cnt_d = cnt_q - 5'd1;
          txd_d = PRE_BYTE;
        end
      end

      SFD, DATA: begin
        if (!rd_g) begin
          state_d = IPG;
          cnt_d   = IPG_RELOAD;
          gnt_d   = 2'b00;
          done_d  = 1'b0;
        end else if (!req_g) begin
          // Requester vanished mid-frame: flag one errored byte, then gap.
          state_d = DATA;
          done_d  = 1'b1;
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
        end else begin
          state_d = DATA;
          done_d  = last_g;
          txd_d   = data_g;
          tx_en_d = 1'b1;
        end
      end

      IPG: begin
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        gnt_d   = 2'b00;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge gtx_clk) begin
    if (mr_main_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      done_q     <= 1'b0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      done_q     <= done_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
    end
  end

  assign bus.gnt0  = gnt_q[0];
  assign bus.gnt1  = gnt_q[1];
  assign bus.rd0   = rd_g && gnt_q[0];
  assign bus.rd1   = rd_g && gnt_q[1];
  assign bus.TXD   = txd_q;
  assign bus.TX_EN = tx_en_q;
  assign bus.TX_ER = tx_er_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized bench for tx_frame_scheduler: two requester models feed frames and a
// trace-level reference predicts every GMII/grant/rd cycle from the frame contents.
module tb_tx_frame_scheduler;

  localparam int PRE = 7;
  localparam int IPG = 11;

  logic gtx_clk = 1'b0;
  logic mr_main_reset;

  tx_frame_scheduler_if bus ();

  tx_frame_scheduler #(
    .PREAMBLE_LEN(PRE),
    .IPG_CYCLES  (IPG)
  ) dut (
    .gtx_clk      (gtx_clk),
    .mr_main_reset(mr_main_reset),
    .bus          (bus)
  );

  always #5 gtx_clk = ~gtx_clk;

  // One predicted output cycle.
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] txd;
    logic [1:0] gnt;
    logic [1:0] rd;
    logic       busy;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t exp_cur = '0;
  int   rr_last = 1;
  int   win;

  int vectors     = 0;
  int miscompares = 0;

  // Requester state: the frame being offered, how far it has been consumed,
  // and an optional planned underrun after fr_k bytes.
  logic [7:0] fr_bytes [2][16];
  int         fr_len   [2];
  bit         fr_und   [2];
  int         fr_k     [2];
  int         idx      [2];
  bit         has_frame[2];
  bit         pending  [2];
  int         idle_wait[2];
  bit         enable   [2];
  int         mode;

  function automatic cyc_t mk(input logic en, input logic er, input logic [7:0] txd,
                              input logic [1:0] gnt, input logic [1:0] rd, input logic busy);
    cyc_t c;
    c.en   = en;
    c.er   = er;
    c.txd  = txd;
    c.gnt  = gnt;
    c.rd   = rd;
    c.busy = busy;
    return c;
  endfunction

  // Whole-frame expectation: preamble, SFD, bytes or underrun marker, gap, idle.
  function automatic void build_frame(input int w);
    logic [1:0] g;
    g = (w == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < PRE; i++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, g, 2'b00, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, g, g, 1'b1));
    if (!fr_und[w]) begin
      for (int i = 0; i < fr_len[w]; i++)
        exp_q.push_back(mk(1'b1, 1'b0, fr_bytes[w][i], g, (i < fr_len[w] - 1) ? g : 2'b00, 1'b1));
    end else begin
      for (int i = 0; i < fr_k[w]; i++)
        exp_q.push_back(mk(1'b1, 1'b0, fr_bytes[w][i], g, g, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b1, 8'h00, g, 2'b00, 1'b1));
    end
    for (int i = 0; i < IPG; i++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0));
  endfunction

  // Reference model: advances one predicted cycle per rising edge.
  always @(posedge gtx_clk) begin
    if (mr_main_reset) begin
      exp_q.delete();
      rr_last = 1;
      exp_cur = '0;
    end else if (exp_q.size() != 0) begin
      exp_cur = exp_q.pop_front();
    end else if (bus.req0 || bus.req1) begin
      if (bus.req0 && bus.req1) win = (rr_last == 0) ? 1 : 0;
      else                      win = bus.req1 ? 1 : 0;
      rr_last = win;
      build_frame(win);
      exp_cur = exp_q.pop_front();
    end else begin
      exp_cur = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  task automatic load_frame(input int r);
    has_frame[r] = 1'b1;
    idx[r]       = 0;
    fr_und[r]    = 1'b0;
    fr_k[r]      = 0;
    case (mode)
      1: begin
        fr_len[r] = 3;
        fr_bytes[r][0] = 8'hA1;
        fr_bytes[r][1] = 8'hA2;
        fr_bytes[r][2] = 8'hA3;
      end
      2: begin
        fr_len[r] = 1;
        fr_bytes[r][0] = 8'h5A;
      end
      3: begin
        fr_len[r] = 4;
        for (int i = 0; i < 4; i++) fr_bytes[r][i] = 8'hB0 + 8'(i);
        fr_und[r] = 1'b1;
        fr_k[r]   = 2;
      end
      default: begin
        fr_len[r] = int'($urandom_range(1, 6));
        for (int i = 0; i < fr_len[r]; i++) fr_bytes[r][i] = 8'($urandom);
        if (fr_len[r] >= 2 && $urandom_range(0, 4) == 0) begin
          fr_und[r] = 1'b1;
          fr_k[r]   = int'($urandom_range(1, fr_len[r] - 1));
        end
      end
    endcase
  endtask

  // One cycle: retire the byte consumed at the last edge, drive new requester
  // inputs, then check the cycle's outputs against the model.
  task automatic applyStimulus(input bit rst);
    logic       rq;
    logic [7:0] d;
    logic       l;
    @(negedge gtx_clk);
    mr_main_reset = rst;
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        idx[r]     = 0;
        pending[r] = 1'b0;
      end else if (pending[r]) begin
        pending[r] = 1'b0;
        if (idx[r] == fr_len[r] - 1) begin
          has_frame[r] = 1'b0;
          idle_wait[r] = int'($urandom_range(0, 3));
        end else begin
          idx[r]++;
        end
      end
      if (!has_frame[r] && enable[r]) begin
        if (idle_wait[r] > 0) idle_wait[r]--;
        else load_frame(r);
      end
      rq = 1'b0;
      d  = 8'($urandom);
      l  = 1'($urandom);
      if (has_frame[r]) begin
        if (fr_und[r] && idx[r] == fr_k[r] && !rst) begin
          has_frame[r] = 1'b0;
          idle_wait[r] = int'($urandom_range(1, 4));
        end else begin
          rq = 1'b1;
          d  = fr_bytes[r][idx[r]];
          l  = (idx[r] == fr_len[r] - 1);
        end
      end
      if (r == 0) begin
        bus.req0 = rq; bus.data0 = d; bus.last0 = l;
      end else begin
        bus.req1 = rq; bus.data1 = d; bus.last1 = l;
      end
    end
    #1;
    checkOutput("TXD",   {24'd0, bus.TXD},          {24'd0, exp_cur.txd});
    checkOutput("TX_EN", {31'd0, bus.TX_EN},        {31'd0, exp_cur.en});
    checkOutput("TX_ER", {31'd0, bus.TX_ER},        {31'd0, exp_cur.er});
    checkOutput("gnt",   {30'd0, bus.gnt1, bus.gnt0}, {30'd0, exp_cur.gnt});
    checkOutput("rd",    {30'd0, bus.rd1, bus.rd0},   {30'd0, exp_cur.rd});
    checkOutput("busy",  {31'd0, bus.busy},         {31'd0, exp_cur.busy});
    pending[0] = !rst && bus.rd0 && bus.req0;
    pending[1] = !rst && bus.rd1 && bus.req1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  // Offer exactly one frame of the given kind on requester r.
  task automatic one_frame(input int r, input int m);
    mode      = m;
    enable[r] = 1'b1;
    applyStimulus(1'b0);
    enable[r] = 1'b0;
  endtask

  initial begin
    mr_main_reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 8'h00; bus.data1 = 8'h00;
    bus.last0 = 1'b0; bus.last1 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      has_frame[r] = 1'b0; pending[r] = 1'b0; idle_wait[r] = 0;
      enable[r] = 1'b0; idx[r] = 0; fr_len[r] = 1; fr_und[r] = 1'b0; fr_k[r] = 0;
    end
    mode = 0;
    $display("[TB] start");

    // Reset state.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);

    // Three-byte frame, then a one-byte frame.
    one_frame(0, 1);
    run(30);
    one_frame(0, 2);
    run(25);

    // Underrun on requester 1, then a normal frame on requester 0.
    one_frame(1, 3);
    one_frame(0, 1);
    run(60);

    // Reset pulsed during preamble with req0 held high.
    one_frame(0, 1);
    run(3);
    applyStimulus(1'b1);
    run(40);

    // Random traffic on both requesters.
    mode      = 0;
    enable[0] = 1'b1;
    enable[1] = 1'b1;
    run(3000);
    enable[0] = 1'b0;
    enable[1] = 1'b0;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
